// File: rtl/coeff_mem_arbiter_pkg.sv
// Shared definitions for the coefficient memory arbiter and its memory model.
//   - Default coefficient word width and word count.
//   - Address-width derivation.
//   - Arbiter grant state enumeration.
package coeff_mem_arbiter_pkg;

  localparam int unsigned DepthDefault      = 24;
  localparam int unsigned WordsDefault      = 5;
  localparam int unsigned WrBurstMaxDefault = 4;

  // Bits needed to address `words` entries; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
    StRd   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/memory_model.sv
// Single-port coefficient storage with a registered read port.
// Ports:
//   clk     - clock, rising edge
//   mem_ce  - access enable
//   mem_we  - write enable (qualified by mem_ce)
//   mem_a   - word address
//   mem_d   - write data
//   mem_q   - read data, valid the cycle after a read access
// Contents and mem_q are deliberately not reset.
module memory_model
  import coeff_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DepthDefault,
  parameter int unsigned WORDS = WordsDefault,
  localparam int unsigned AW   = addr_width(WORDS)
) (
  input  logic             clk,
  input  logic             mem_ce,
  input  logic             mem_we,
  input  logic [AW-1:0]    mem_a,
  input  logic [DEPTH-1:0] mem_d,
  output logic [DEPTH-1:0] mem_q
);

  logic [DEPTH-1:0] mem_array [WORDS];

  always_ff @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        mem_array[mem_a] <= mem_d;
      end else begin
        mem_q <= mem_array[mem_a];
      end
    end
  end

endmodule

// File: rtl/coeff_mem_arbiter.sv
// Arbitrates a host configuration write port and a tree-walker read port onto
// one single-port coefficient memory. Writes win by default; a pending read is
// forced through after WR_BURST_MAX consecutive writes so it cannot starve.
// Ports:
//   clk, reset            - clock and synchronous active-low reset
//   cfg_valid/ready/addr/data - host write request and grant
//   rd_valid/ready/addr   - read request and grant
//   rsp_valid/rsp_data    - read response, one cycle after the read grant
//   mem_ce/we/a/d, mem_q  - memory port (mem_q is the registered read data)
//   err_oob               - sticky: an out-of-range address was accepted
module coeff_mem_arbiter
  import coeff_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = DepthDefault,
  parameter int unsigned WORDS        = WordsDefault,
  parameter int unsigned WR_BURST_MAX = WrBurstMaxDefault,
  localparam int unsigned AW          = addr_width(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [DEPTH-1:0] cfg_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rsp_valid,
  output logic [DEPTH-1:0] rsp_data,
  output logic             mem_ce,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [DEPTH-1:0] mem_d,
  input  logic [DEPTH-1:0] mem_q,
  output logic             err_oob
);

  localparam int unsigned CW = addr_width(WR_BURST_MAX + 1);

  // state_d is this cycle's grant decision; state_q remembers last cycle's
  // grant so a read response can be issued one cycle later.
  arb_state_e    state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          rd_oob_q, rd_oob_d;
  logic          err_q, err_d;

  logic burst_full;
  logic wr_in_range;
  logic rd_in_range;

  assign burst_full  = (burst_q == CW'(WR_BURST_MAX));
  assign wr_in_range = (32'(cfg_addr) < WORDS);
  assign rd_in_range = (32'(rd_addr) < WORDS);

  always_comb begin
    state_d   = StIdle;
    burst_d   = burst_q;
    rd_oob_d  = 1'b0;
    err_d     = err_q;
    cfg_ready = 1'b0;
    rd_ready  = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_d     = '0;

    // Grants are suppressed combinationally while reset is held low.
    if (reset) begin
      if (rd_valid && (!cfg_valid || burst_full)) begin
        state_d = StRd;
      end else if (cfg_valid) begin
        state_d = StWr;
      end
    end

    unique case (state_d)
      StWr: begin
        cfg_ready = 1'b1;
        if (wr_in_range) begin
          mem_ce = 1'b1;
          mem_we = 1'b1;
          mem_a  = cfg_addr;
          mem_d  = cfg_data;
        end else begin
          err_d = 1'b1;
        end
      end
      StRd: begin
        rd_ready = 1'b1;
        if (rd_in_range) begin
          mem_ce = 1'b1;
          mem_a  = rd_addr;
        end else begin
          // Still answered next cycle, but with zero data.
          err_d    = 1'b1;
          rd_oob_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Count writes that held off a waiting read; any read grant or an idle
    // read side restarts the count.
    if (state_d == StRd || !rd_valid) begin
      burst_d = '0;
    end else if (state_d == StWr && !burst_full) begin
      burst_d = burst_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      burst_q  <= '0;
      rd_oob_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      rd_oob_q <= rd_oob_d;
      err_q    <= err_d;
    end
  end

  // Gating by reset makes a response in flight vanish the moment reset is
  // applied, and keeps every output at its reset value during reset.
  assign rsp_valid = reset && (state_q == StRd);
  assign rsp_data  = (rsp_valid && !rd_oob_q) ? mem_q : '0;
  assign err_oob   = reset && err_q;

endmodule

// File: tb/tb_coeff_mem_arbiter.sv
module tb_coeff_mem_arbiter;

  localparam int unsigned DEPTH = 24;
  localparam int unsigned WORDS = 5;
  localparam int unsigned MAXB  = 4;
  localparam int unsigned AW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             cfg_valid, cfg_ready;
  logic [AW-1:0]    cfg_addr;
  logic [DEPTH-1:0] cfg_data;
  logic             rd_valid, rd_ready;
  logic [AW-1:0]    rd_addr;
  logic             rsp_valid;
  logic [DEPTH-1:0] rsp_data;
  logic             mem_ce, mem_we;
  logic [AW-1:0]    mem_a;
  logic [DEPTH-1:0] mem_d, mem_q;
  logic             err_oob;

  coeff_mem_arbiter #(
    .DEPTH        (DEPTH),
    .WORDS        (WORDS),
    .WR_BURST_MAX (MAXB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .mem_q     (mem_q),
    .err_oob   (err_oob)
  );

  memory_model #(
    .DEPTH (DEPTH),
    .WORDS (WORDS)
  ) u_mem (
    .clk    (clk),
    .mem_ce (mem_ce),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_d  (mem_d),
    .mem_q  (mem_q)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory image, write-burst count, expected next response.
  logic [DEPTH-1:0] ref_mem [WORDS];
  int unsigned      burst = 0;
  bit               m_rv  = 1'b0;
  logic [DEPTH-1:0] m_rd  = '0;
  bit               m_err = 1'b0;

  // DUT values captured at the last mid-cycle sample point.
  logic obs_r, obs_ce, obs_rv, obs_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, update model after
  // the next posedge, return at posedge+1.
  task automatic step(input bit rst_n, input bit cv, input int unsigned ca,
                      input logic [DEPTH-1:0] cd, input bit rv, input int unsigned ra);
    bit g_r, g_w, w_ok, r_ok;
    logic [AW-1:0] exp_a;
    reset     = rst_n;
    cfg_valid = cv;
    cfg_addr  = AW'(ca);
    cfg_data  = cd;
    rd_valid  = rv;
    rd_addr   = AW'(ra);
    g_r  = rst_n && rv && (!cv || burst == MAXB);
    g_w  = rst_n && cv && !g_r;
    w_ok = (ca < WORDS);
    r_ok = (ra < WORDS);
    exp_a = (g_w && w_ok) ? AW'(ca) : (g_r && r_ok) ? AW'(ra) : '0;
    #4;
    obs_r   = rd_ready;
    obs_ce  = mem_ce;
    obs_rv  = rsp_valid;
    obs_err = err_oob;
    chk("cfg_ready", 32'(cfg_ready), 32'(g_w));
    chk("rd_ready", 32'(rd_ready), 32'(g_r));
    chk("mem_ce", 32'(mem_ce), 32'((g_w && w_ok) || (g_r && r_ok)));
    chk("mem_we", 32'(mem_we), 32'(g_w && w_ok));
    chk("mem_a", 32'(mem_a), 32'(exp_a));
    chk("mem_d", 32'(mem_d), (g_w && w_ok) ? 32'(cd) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(rst_n && m_rv));
    chk("rsp_data", 32'(rsp_data), (rst_n && m_rv) ? 32'(m_rd) : 32'd0);
    chk("err_oob", 32'(err_oob), 32'(rst_n && m_err));
    @(posedge clk);
    if (!rst_n) begin
      burst = 0;
      m_rv  = 1'b0;
      m_rd  = '0;
      m_err = 1'b0;
    end else begin
      if (g_w && w_ok) ref_mem[ca] = cd;
      if ((g_w && !w_ok) || (g_r && !r_ok)) m_err = 1'b1;
      m_rv = g_r;
      m_rd = (g_r && r_ok) ? ref_mem[ra] : '0;
      if (g_r || !rv) burst = 0;
      else if (g_w && burst < MAXB) burst++;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 0, '0, 1'b0, 0);
  endtask

  initial begin
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    rd_valid  = 1'b0;
    rd_addr   = '0;
    @(posedge clk);
    #1;

    // Reset: requests present but nothing granted.
    step(1'b0, 1'b1, 1, 24'h123456, 1'b1, 2);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0);
    chk("reset_rsp_valid", 32'(obs_rv), 32'd0);

    // Populate every word.
    for (int i = 0; i < int'(WORDS); i++) begin
      step(1'b1, 1'b1, i, DEPTH'($urandom), 1'b0, 0);
    end

    // Write then read the same address on the next cycle.
    step(1'b1, 1'b1, 2, 24'hABCDEF, 1'b0, 0);
    step(1'b1, 1'b0, 0, '0, 1'b1, 2);
    chk("wr_rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rd_rsp_data", 32'(rsp_data), 32'h00ABCDEF);
    idle();

    // Back-to-back reads of every word.
    for (int i = 0; i < int'(WORDS); i++) begin
      step(1'b1, 1'b0, 0, '0, 1'b1, i);
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_rsp_data", 32'(rsp_data), 32'(ref_mem[i]));
    end
    idle();

    // Both sides saturated: four writes then one read, repeating.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, $urandom_range(0, WORDS - 1), DEPTH'($urandom), 1'b1,
           $urandom_range(0, WORDS - 1));
      chk("burst_rd_grant", 32'(obs_r), 32'((i % 5) == 4));
    end
    idle();

    // Idle inputs: no accesses, no responses.
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("idle_mem_ce", 32'(obs_ce), 32'd0);
      chk("idle_rsp_valid", 32'(obs_rv), 32'd0);
    end

    // Out-of-range read.
    step(1'b1, 1'b0, 0, '0, 1'b1, 7);
    chk("oob_mem_ce", 32'(obs_ce), 32'd0);
    chk("oob_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("oob_rsp_data", 32'(rsp_data), 32'd0);
    chk("oob_err", 32'(err_oob), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("oob_err_sticky", 32'(obs_err), 32'd1);
    end

    // Read granted, then reset the following cycle: response is dropped.
    step(1'b1, 1'b0, 0, '0, 1'b1, 1);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0);
    chk("rst_drop_rsp_valid", 32'(obs_rv), 32'd0);
    chk("rst_clear_err", 32'(obs_err), 32'd0);
    idle();
    chk("post_rst_rsp_valid", 32'(obs_rv), 32'd0);
    chk("post_rst_err", 32'(obs_err), 32'd0);

    // Memory survives reset.
    step(1'b1, 1'b0, 0, '0, 1'b1, 2);
    chk("mem_kept_rsp_data", 32'(rsp_data), 32'(ref_mem[2]));
    idle();

    // Random traffic, including out-of-range addresses and sporadic resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 7), DEPTH'($urandom), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 7));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coeff_mem_arbiter.md
COEFF_MEM_ARBITER -- requirements
Module: coeff_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 24, coefficient word width in bits.
REQ-002 Parameter WORDS, default 5, number of coefficient words; AW = $clog2(WORDS) address bits.
REQ-003 Parameter WR_BURST_MAX, default 4, maximum consecutive write grants while a read is pending.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-006 cfg_valid  input  1  host write request.
REQ-007 cfg_ready  output  1  write request granted this cycle.
REQ-008 cfg_addr  input  AW  write word address.
REQ-009 cfg_data  input  DEPTH  write word data.
REQ-010 rd_valid  input  1  tree-walker read request.
REQ-011 rd_ready  output  1  read request granted this cycle.
REQ-012 rd_addr  input  AW  read word address.
REQ-013 rsp_valid  output  1  read response valid; no backpressure.
REQ-014 rsp_data  output  DEPTH  read response word.
REQ-015 mem_ce, mem_we  output  1 each  memory enable and write enable.
REQ-016 mem_a  output  AW, mem_d  output  DEPTH  memory address and write data.
REQ-017 mem_q  input  DEPTH  memory registered read data, valid one cycle after mem_ce.
REQ-018 err_oob  output  1  sticky flag: an out-of-range address was accepted.

Function
REQ-019 A transfer occurs when valid and ready are both high; ready is combinational from the valids and the arbiter state; at most one grant per cycle.
REQ-020 Default priority is write; the read is granted when cfg_valid is low, or when the burst counter equals WR_BURST_MAX and rd_valid is high.
REQ-021 The burst counter increments on each write grant while rd_valid is high, clears on any read grant or any cycle with rd_valid low, and saturates at WR_BURST_MAX.
REQ-022 Arbiter states are IDLE (no grant), WR (write granted) and RD (read granted); the state is re-evaluated every cycle with no dead cycles between grants.
REQ-023 On a write grant with in-range address: mem_ce=1, mem_we=1, mem_a=cfg_addr, mem_d=cfg_data in the same cycle; no response is produced.
REQ-024 On a read grant with in-range address: mem_ce=1, mem_we=0, mem_a=rd_addr.
REQ-025 For that read, rsp_valid=1 and rsp_data=mem_q exactly one cycle after the grant; back-to-back reads give back-to-back responses.
REQ-026 An address >= WORDS is accepted (ready high) with mem_ce=0 and err_oob set; an OOB read still gives rsp_valid one cycle later with rsp_data=0.
REQ-027 When no grant occurs: mem_ce=0, mem_we=0, mem_a=0, mem_d=0.
REQ-028 A write followed by a read of the same address in the next cycle returns the new data; a same-cycle conflict cannot occur (single grant).
REQ-029 rsp_data is 0 whenever rsp_valid is 0.

Reset
REQ-030 While reset=0 at a clock edge: no grants; cfg_ready=0, rd_ready=0, mem_ce=0, mem_we=0, rsp_valid=0, rsp_data=0, err_oob=0, burst counter=0, state=IDLE.
REQ-031 A read granted in the cycle before reset asserts produces no response; the pending-response flag is cleared.
REQ-032 Memory contents are not modified by reset.

Structure
REQ-033 The shared package holds the DEPTH/WORDS defaults, the AW derivation and the arbiter state enumeration.
REQ-034 The arbiter instantiates no sub-module; memory_model is instantiated alongside it at the next level up.
REQ-035 The bench wires coeff_mem_arbiter to memory_model with mem_* connected port-to-port.

Verification
REQ-036 Write addr 2 data 0xABCDEF, then read addr 2 -> rsp_valid one cycle after the read grant, rsp_data=0xABCDEF.
REQ-037 cfg_valid and rd_valid both held high, WR_BURST_MAX=4 -> grant pattern W,W,W,W,R repeating; no read starves.
REQ-038 Read addresses 0,1,2,3,4 on consecutive cycles -> five consecutive rsp_valid cycles with the matching file contents.
REQ-039 Read addr 7 with WORDS=5 -> mem_ce=0, rsp_valid=1 with rsp_data=0 next cycle, err_oob=1 until reset.
REQ-040 Read granted, reset low the next cycle -> rsp_valid=0, err_oob=0, all outputs at reset values.
REQ-041 Idle inputs for 10 cycles -> mem_ce=0 and no responses throughout.
